// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch and data access.
// Optional macro ARB_RR_EN selects round-robin arbitration under contention; the default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    HALTED
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              halt_pend_q;
  logic              owner_q;      // 1 = data port, 0 = fetch port
  logic              is_store_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic              halt_now;
  logic              any_req;
  logic              grant_data;
  logic              start;
  logic              capture;

  assign halt_now = halt_pend_q | hlt;
  assign any_req  = d_req | if_req;

`ifdef ARB_RR_EN
  logic last_owner_q;  // 1 = data port, 0 = fetch port

  // Under contention, the port that did not win last time is served.
  always_comb begin
    grant_data = d_req;
    if (d_req && if_req) grant_data = ~last_owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b0;
    end else if (start) begin
      last_owner_q <= grant_data;
    end
  end
`else
  always_comb begin
    grant_data = d_req;
  end
`endif

  assign start   = (state_q == IDLE) && !halt_now && any_req;
  assign capture = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (halt_now)     state_d = HALTED;
        else if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_now;
    end
  end

  // The memory strobe is registered at the grant edge so it lines up with ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      is_store_q  <= 1'b0;
    end else begin
      mem_en_q <= start;
      mem_we_q <= start & grant_data & d_we;
      if (start) begin
        mem_addr_q <= grant_data ? d_addr : if_addr;
        owner_q    <= grant_data;
        is_store_q <= grant_data & d_we;
        if (grant_data && d_we) mem_wdata_q <= d_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (!owner_q)         if_rdata_q <= mem_rdata;
      else if (!is_store_q) d_rdata_q  <= mem_rdata;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = (state_q == DONE) && !owner_q;
  assign d_valid   = (state_q == DONE) && owner_q;
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with MEM_LAT=4, instance 1 with MEM_LAT=1, each with a memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hlt[2], if_req[2], d_req[2], d_we[2];
  logic [15:0] if_addr[2], d_addr[2], d_wdata[2], mem_rdata[2];
  logic        if_valid[2], if_stall[2], d_valid[2], d_stall[2];
  logic        mem_en[2], mem_we[2], halted[2];
  logic [15:0] if_rdata[2], d_rdata[2], mem_addr[2], mem_wdata[2];

  int errors = 0;
  int checks = 0;

  logic [15:0] env_mem [bit [16:0]];
  logic [15:0] ref_mem [bit [16:0]];
  bit          last_d [2];  // last served port per instance, tracked from stimulus

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .hlt(hlt[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
    .if_valid(if_valid[0]), .if_stall(if_stall[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_valid(d_valid[0]), .d_stall(d_stall[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .halted(halted[0])
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .hlt(hlt[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
    .if_valid(if_valid[1]), .if_stall(if_stall[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_valid(d_valid[1]), .d_stall(d_stall[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .halted(halted[1])
  );

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] env_rd(input int k, input logic [15:0] a);
    bit [16:0] key;
    key = {k[0], a};
    return env_mem.exists(key) ? env_mem[key] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int k, input logic [15:0] a);
    bit [16:0] key;
    key = {k[0], a};
    return ref_mem.exists(key) ? ref_mem[key] : dflt(a);
  endfunction

  // Memory: read data appears exactly MEM_LAT cycles after the strobe; noise otherwise.
  bit          pv [2][16];
  logic [15:0] pa [2][16];
  always @(posedge clk) begin
    int lat;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 4 : 1;
      for (int s = 15; s > 0; s--) begin
        pv[k][s] = pv[k][s-1];
        pa[k][s] = pa[k][s-1];
      end
      pv[k][0] = mem_en[k] & ~mem_we[k];
      pa[k][0] = mem_addr[k];
      if (mem_en[k] && mem_we[k]) env_mem[{k[0], mem_addr[k]}] = mem_wdata[k];
      mem_rdata[k] <= pv[k][lat-1] ? env_rd(k, pa[k][lat-1]) : 16'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on one port; b2b=1 means the request was held through the previous valid cycle.
  task automatic access(input int k, input bit dport, input bit we, input logic [15:0] addr,
                        input logic [15:0] wd, input int b2b, input int hlt_at, input string tag);
    int lat = (k == 0) ? 4 : 1;
    int en_cyc = -1;
    int en_n = 0;
    int v_cyc = -1;
    bit stall_ok = 1'b1;
    bit other_ok = 1'b1;
    bit issue_ok = 1'b1;
    logic [15:0] exp_rd, old_d, got_rd;
    if (b2b == 0) @(negedge clk);
    old_d  = d_rdata[k];
    exp_rd = (dport && we) ? old_d : ref_rd(k, addr);
    if (dport) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    #1;
    if (b2b == 0 && (dport ? d_stall[k] : if_stall[k]) !== 1'b1) stall_ok = 1'b0;
    for (int c = 1; c <= 40 && v_cyc < 0; c++) begin
      @(negedge clk);
      hlt[k] = (c == hlt_at);
      if (mem_en[k] === 1'b1) begin
        en_n++;
        en_cyc = c;
        if (mem_addr[k] !== addr || mem_we[k] !== (dport & we)) issue_ok = 1'b0;
        if (dport && we && mem_wdata[k] !== wd) issue_ok = 1'b0;
      end
      if ((dport ? if_valid[k] : d_valid[k]) !== 1'b0) other_ok = 1'b0;
      if ((dport ? d_valid[k] : if_valid[k]) === 1'b1) begin
        v_cyc = c;
        if ((dport ? d_stall[k] : if_stall[k]) !== 1'b0) stall_ok = 1'b0;
      end else if ((dport ? d_stall[k] : if_stall[k]) !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    hlt[k] = 1'b0;
    got_rd = dport ? d_rdata[k] : if_rdata[k];
    if (dport) d_req[k] = 1'b0; else if_req[k] = 1'b0;
    if (dport && we) ref_mem[{k[0], addr}] = wd;
    last_d[k] = dport;
    chk({tag, "/en_cycle"}, en_cyc, 1 + b2b);
    chk({tag, "/en_count"}, en_n, 1);
    chk({tag, "/issue"}, {31'd0, issue_ok}, 1);
    chk({tag, "/valid_cycle"}, v_cyc, lat + 2 + b2b);
    chk({tag, "/rdata"}, {16'd0, got_rd}, {16'd0, exp_rd});
    chk({tag, "/stall"}, {31'd0, stall_ok}, 1);
    chk({tag, "/other_valid"}, {31'd0, other_ok}, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit d_pend, i_pend, exp_d;
    int d_cnt, got, r, k, dp, we;
    logic [15:0] a, w, got_rd;
    bit quiet;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hlt[i] = 0; if_req[i] = 0; d_req[i] = 0; d_we[i] = 0;
      if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
      last_d[i] = 0;
    end
    env_mem[{1'b0, 16'h0010}] = 16'hA123;
    ref_mem[{1'b0, 16'h0010}] = 16'hA123;
    repeat (3) @(negedge clk);
    chk("reset/mem_en", {31'd0, mem_en[0]}, 0);
    chk("reset/valids", {30'd0, if_valid[0], d_valid[0]}, 0);
    chk("reset/rdata", {if_rdata[0], d_rdata[0]}, 0);
    chk("reset/mem_addr_halted", {15'd0, halted[0], mem_addr[0]}, 0);
    rst_n = 1'b1;

    // Fetch then store on the MEM_LAT=4 instance, then read the stored word back.
    access(0, 0, 0, 16'h0010, 16'h0000, 0, 0, "t1_fetch");
    access(0, 1, 1, 16'h0040, 16'hBEEF, 0, 0, "t2_store");
    access(0, 1, 0, 16'h0040, 16'h0000, 0, 0, "t2_readback");

    // Contention: both requests raised together and held.
    @(negedge clk);
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 16'h0080;
    if_req[0] = 1; if_addr[0] = 16'h0100;
    d_pend = 1; i_pend = 1; d_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      if (d_pend && i_pend) begin
`ifdef ARB_RR_EN
        exp_d = ~last_d[0];
`else
        exp_d = 1'b1;
`endif
      end else begin
        exp_d = d_pend;
      end
      got = 2;
      for (int c = 0; c < 20 && got == 2; c++) begin
        @(negedge clk);
        if (d_valid[0] === 1'b1)       got = 1;
        else if (if_valid[0] === 1'b1) got = 0;
      end
      got_rd = exp_d ? d_rdata[0] : if_rdata[0];
      chk($sformatf("t3_order%0d", p), got, {31'd0, exp_d});
      chk($sformatf("t3_rdata%0d", p), {16'd0, got_rd},
          {16'd0, ref_rd(0, exp_d ? 16'h0080 : 16'h0100)});
      last_d[0] = exp_d;
      if (exp_d) d_cnt++;
      if (d_cnt == 3 && d_pend) begin
        d_req[0] = 0; d_pend = 0;
      end
    end
    d_req[0] = 0; if_req[0] = 0;

    // MEM_LAT=1: fetch held high across three accesses.
    access(1, 0, 0, 16'h0000, 16'h0000, 0, 0, "t6_a");
    access(1, 0, 0, 16'h0002, 16'h0000, 1, 0, "t6_b");
    access(1, 0, 0, 16'h0004, 16'h0000, 1, 0, "t6_c");

    // Random single-port accesses on both instances against the reference memory.
    for (int j = 0; j < 24; j++) begin
      k  = $urandom_range(0, 1);
      dp = $urandom_range(0, 1);
      we = dp ? $urandom_range(0, 1) : 0;
      r  = $urandom_range(0, 3);
      a  = (r == 0) ? 16'hFFFF : (r == 1) ? 16'($urandom) : {12'h000, 4'($urandom)};
      w  = 16'($urandom);
      access(k, dp[0], we[0], a, w, 0, 0, $sformatf("rnd%0d", j));
    end

    // Reset in the middle of a load.
    @(negedge clk);
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 16'h0080;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst/mem_en_we", {30'd0, mem_en[0], mem_we[0]}, 0);
    chk("t5_rst/valid", {30'd0, d_valid[0], if_valid[0]}, 0);
    chk("t5_rst/rdata", {if_rdata[0], d_rdata[0]}, 0);
    chk("t5_rst/mem_addr", {16'd0, mem_addr[0]}, 0);
    d_req[0] = 0;
    last_d[0] = 0; last_d[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (d_valid[0] !== 1'b0 || mem_en[0] !== 1'b0) quiet = 1'b0;
    end
    chk("t5_no_stale", {31'd0, quiet}, 1);
    access(0, 1, 0, 16'h0080, 16'h0000, 0, 0, "t5_after");

    // Halt pulsed during the WAIT of a fetch.
    access(0, 0, 0, 16'h0010, 16'h0000, 0, 3, "t4_fetch");
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 16'h0040;
    quiet = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (mem_en[0] !== 1'b0 || d_valid[0] !== 1'b0 || d_stall[0] !== 1'b1) quiet = 1'b0;
      if (i >= 1 && halted[0] !== 1'b1) quiet = 1'b0;
    end
    chk("t4_halted_quiet", {31'd0, quiet}, 1);
    chk("t4_halted", {31'd0, halted[0]}, 1);
    d_req[0] = 0;
    #1;
    chk("t4_stall_follows", {31'd0, d_stall[0]}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
